divider_seq: RTL and testbench

//  Sequential unsigned restoring divider, the inverse of the 8x8 multiplier

---
 rtl/divider_seq_if.sv | 30 +++
 rtl/divider_seq.sv | 96 +++++++++
 tb/tb_divider_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/divider_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : divider_seq_if
//  Purpose  : Start/busy/done handshake and operand/result bundle for the
//             sequential divider.
//  Revision : 1.0  initial release
// ============================================================================
interface divider_seq_if #(
    parameter int DW = 8
);
    logic              start;
    logic [2*DW-1:0]   dividend;
    logic [DW-1:0]     divisor;
    logic              busy;
    logic              done;
    logic [2*DW-1:0]   quotient;
    logic [DW-1:0]     remainder;
    logic              div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/divider_seq.sv
`default_nettype none
// ============================================================================
//  Module   : divider_seq
//  Purpose  : Unsigned restoring divider, 2*DW-bit dividend by DW-bit divisor,
//             one quotient bit per clock with start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module divider_seq #(
    parameter int DW = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    divider_seq_if.slave  bus
);
    localparam int              c_CW   = $clog2(2*DW);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(2*DW-1);
    localparam logic [0:0]      c_IDLE = 1'b0;
    localparam logic [0:0]      c_CALC = 1'b1;

    logic [0:0]      r_state;
    logic [c_CW-1:0] r_count;
    logic [2*DW-1:0] r_dvd;
    logic [DW-1:0]   r_dvs;
    logic [DW-1:0]   r_rem;
    logic            r_busy;
    logic            r_done;
    logic [2*DW-1:0] r_quotient;
    logic [DW-1:0]   r_remainder;
    logic            r_dbz;

    logic [DW:0]     w_rshift;
    logic [DW:0]     w_diff;
    logic            w_qbit;
    logic [DW-1:0]   w_rnext;

    // The stored remainder is always < divisor, so its top bit is implicitly
    // zero; the sign of the trial subtraction gives the quotient bit.
    assign w_rshift = {r_rem, r_dvd[2*DW-1]};
    assign w_diff   = w_rshift - {1'b0, r_dvs};
    assign w_qbit   = ~w_diff[DW];
    assign w_rnext  = w_qbit ? w_diff[DW-1:0] : w_rshift[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_count     <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == c_IDLE) begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        r_done      <= 1'b1;
                        r_dbz       <= 1'b1;
                        r_quotient  <= '1;
                        r_remainder <= '0;
                    end else begin
                        r_dvd   <= bus.dividend;
                        r_dvs   <= bus.divisor;
                        r_rem   <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_CALC;
                    end
                end
            end else begin
                // Quotient bits shift in from the bottom as dividend bits leave the top.
                r_dvd   <= {r_dvd[2*DW-2:0], w_qbit};
                r_rem   <= w_rnext;
                r_count <= r_count + c_CW'(1);
                if (r_count == c_LAST) begin
                    r_quotient  <= {r_dvd[2*DW-2:0], w_qbit};
                    r_remainder <= w_rnext;
                    r_dbz       <= 1'b0;
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= c_IDLE;
                end
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;
endmodule
`default_nettype wire

// File: tb/tb_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divider_seq
//  Purpose  : Self-checking bench for divider_seq: vector table, corner-case
//             sequences and random operands against a result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_divider_seq;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    divider_seq_if #(.DW(DW)) bus ();
    divider_seq #(.DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [2*DW-1:0] dvd;
        logic [DW-1:0]   dvs;
        logic [2*DW-1:0] q;
        logic [DW-1:0]   r;
        logic            z;
    } vec_t;

    typedef struct {
        logic [2*DW-1:0] dvd;
        logic [DW-1:0]   dvs;
        logic [2*DW-1:0] q;
        logic [DW-1:0]   r;
        logic            z;
        int unsigned     cyc;
    } exp_t;

    vec_t        vecs [9];
    exp_t        sb [$];
    int unsigned cyc = 0;
    int unsigned passed = 0;
    int unsigned total = 0;
    int unsigned bw = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient",    32'(bus.quotient),    32'(e.q));
                chk("remainder",   32'(bus.remainder),   32'(e.r));
                chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.z));
                chk("latency",     cyc,                  e.cyc);
                chk("busy_at_done", 32'(bus.busy),       32'd0);
                if (!e.z)
                    chk("invariant",
                        32'(bus.quotient) * 32'(e.dvs) + 32'(bus.remainder),
                        32'(e.dvd));
            end
        end
    end

    always @(negedge clk) begin
        if (rst) bw = 0;
        else if (bus.busy) bw++;
        else if (bw != 0) begin
            chk("busy_width", bw, 32'd16);
            bw = 0;
        end
    end

    // Called at a negedge while the DUT can accept; returns after the accepting edge.
    task automatic issue(input logic [2*DW-1:0] a, input logic [DW-1:0] b);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        e.dvd = a;
        e.dvs = b;
        e.z   = (b == '0);
        e.q   = e.z ? '1 : a / 16'(b);
        e.r   = e.z ? '0 : DW'(a % 16'(b));
        e.cyc = cyc + (e.z ? 0 : 2*DW);
        sb.push_back(e);
        bus.start    = 1'b0;
        bus.dividend = 16'($urandom);
        bus.divisor  = 8'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb.size() == 0) return;
        end
        chk("timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,  1'b0};
        vecs[1] = '{16'd40000, 8'd200, 16'd200,   8'd0,  1'b0};
        vecs[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0,  1'b0};
        vecs[3] = '{16'd3,     8'd10,  16'd0,     8'd3,  1'b0};
        vecs[4] = '{16'd65535, 8'd255, 16'd257,   8'd0,  1'b0};
        vecs[5] = '{16'd5,     8'd0,   16'hFFFF,  8'd0,  1'b1};
        vecs[6] = '{16'd0,     8'd5,   16'd0,     8'd0,  1'b0};
        vecs[7] = '{16'd65025, 8'd255, 16'd255,   8'd0,  1'b0};
        vecs[8] = '{16'd65535, 8'd2,   16'd32767, 8'd1,  1'b0};

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",      32'(bus.busy),        32'd0);
        chk("rst_done",      32'(bus.done),        32'd0);
        chk("rst_quotient",  32'(bus.quotient),    32'd0);
        chk("rst_remainder", 32'(bus.remainder),   32'd0);
        chk("rst_dbz",       32'(bus.div_by_zero), 32'd0);
        rst = 1'b0;

        // Table vectors: hand-computed expectations, scoreboard checks timing.
        foreach (vecs[i]) begin
            chk("vec_q_table", 32'(vecs[i].q), 32'(vecs[i].z ? 16'hFFFF : vecs[i].dvd / 16'(vecs[i].dvs)));
            issue(vecs[i].dvd, vecs[i].dvs);
            if (vecs[i].z) chk("dbz_busy", 32'(bus.busy), 32'd0);
            wait_idle();
            chk("vec_q", 32'(bus.quotient),    32'(vecs[i].q));
            chk("vec_r", 32'(bus.remainder),   32'(vecs[i].r));
            chk("vec_z", 32'(bus.div_by_zero), 32'(vecs[i].z));
        end

        // Start while busy is ignored; then back-to-back start in the done cycle.
        issue(16'd700, 8'd7);
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd9; bus.divisor = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 30 && !bus.done; i++) @(negedge clk);
        chk("b2b_done_seen", 32'(bus.done), 32'd1);
        chk("b2b_first_q",   32'(bus.quotient), 32'd100);
        issue(16'd9, 8'd3);
        chk("b2b_held_q", 32'(bus.quotient), 32'd100);
        wait_idle();
        chk("b2b_second_q", 32'(bus.quotient), 32'd3);

        // Reset mid-operation aborts with no done.
        issue(16'd1000, 8'd7);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy",      32'(bus.busy),        32'd0);
        chk("abort_done",      32'(bus.done),        32'd0);
        chk("abort_quotient",  32'(bus.quotient),    32'd0);
        chk("abort_remainder", 32'(bus.remainder),   32'd0);
        rst = 1'b0;
        sb.delete();
        repeat (20) @(negedge clk);
        issue(16'd500, 8'd9);
        wait_idle();
        chk("after_abort_q", 32'(bus.quotient),  32'd55);
        chk("after_abort_r", 32'(bus.remainder), 32'd5);

        // Random operands with nonzero divisor.
        for (int i = 0; i < 2000; i++) begin
            issue(16'($urandom), 8'($urandom_range(255, 1)));
            wait_idle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
